// File: rtl/mem_arbiter_if.sv
// Bundle of CPU, DMA and CACHE-side signals around the memory arbiter.
// The slave modport is the arbiter's view; master is the surrounding environment.
interface mem_arbiter_if #(
  parameter int unsigned AW = 20,
  parameter int unsigned DW = 32
);
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_din;
  logic [3:0]    cpu_wmask;
  logic          cpu_mreq;
  logic [DW-1:0] cpu_dout;
  logic          cpu_mrdy;

  logic [AW-1:0] dma_addr;
  logic          dma_mreq;
  logic [DW-1:0] dma_dout;
  logic          dma_mrdy;

  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_din;
  logic [3:0]    mem_wmask;
  logic          mem_mreq;
  logic [DW-1:0] mem_dout;
  logic          mem_mrdy;

  logic          grant_cpu;
  logic          grant_dma;

  modport slave (
    input  cpu_addr, cpu_din, cpu_wmask, cpu_mreq,
    input  dma_addr, dma_mreq,
    input  mem_dout, mem_mrdy,
    output cpu_dout, cpu_mrdy, dma_dout, dma_mrdy,
    output mem_addr, mem_din, mem_wmask, mem_mreq,
    output grant_cpu, grant_dma
  );

  modport master (
    output cpu_addr, cpu_din, cpu_wmask, cpu_mreq,
    output dma_addr, dma_mreq,
    output mem_dout, mem_mrdy,
    input  cpu_dout, cpu_mrdy, dma_dout, dma_mrdy,
    input  mem_addr, mem_din, mem_wmask, mem_mreq,
    input  grant_cpu, grant_dma
  );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing the CACHE port between the CPU and a read-only DMA,
// with a bounded DMA burst and a one-cycle idle gap on every owner change.
module mem_arbiter #(
  parameter int unsigned AW        = 20,
  parameter int unsigned DW        = 32,
  parameter int unsigned DMA_BURST = 8
) (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.slave  bus
);
  localparam int unsigned CW = 8;

  typedef enum logic [1:0] {S_IDLE, S_CPU, S_DMA} state_t;

  state_t        r_state, w_state_nxt;
  logic          r_last, w_last_nxt;
  logic [CW-1:0] r_bcnt, w_bcnt_nxt;
  logic [CW:0]   w_bcnt_sum;
  logic [CW-1:0] w_bcnt_inc;
  logic          w_burst_done;

  logic [AW-1:0] w_mem_addr;
  logic [DW-1:0] w_mem_din;
  logic [3:0]    w_mem_wmask;
  logic          w_mem_mreq;
  logic          w_cpu_mrdy;
  logic          w_dma_mrdy;

  // Saturating burst counter increment; the carry bit also feeds the limit compare
  assign w_bcnt_sum   = {1'b0, r_bcnt} + (CW+1)'(1);
  assign w_bcnt_inc   = w_bcnt_sum[CW] ? r_bcnt : w_bcnt_sum[CW-1:0];
  assign w_burst_done = (w_bcnt_sum >= (CW+1)'(DMA_BURST));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_last  <= 1'b1;
      r_bcnt  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_last  <= w_last_nxt;
      r_bcnt  <= w_bcnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_last_nxt  = r_last;
    w_bcnt_nxt  = r_bcnt;
    w_mem_addr  = bus.cpu_addr;
    w_mem_din   = bus.cpu_din;
    w_mem_wmask = 4'h0;
    w_mem_mreq  = 1'b0;
    w_cpu_mrdy  = 1'b0;
    w_dma_mrdy  = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (bus.cpu_mreq && bus.dma_mreq) begin
          w_state_nxt = r_last ? S_CPU : S_DMA;
          if (!r_last) w_bcnt_nxt = '0;
        end else if (bus.cpu_mreq) begin
          w_state_nxt = S_CPU;
        end else if (bus.dma_mreq) begin
          w_state_nxt = S_DMA;
          w_bcnt_nxt  = '0;
        end
      end

      S_CPU: begin
        w_mem_wmask = bus.cpu_wmask;
        w_mem_mreq  = bus.cpu_mreq;
        w_cpu_mrdy  = bus.mem_mrdy;
        if (bus.mem_mrdy) begin
          w_last_nxt = 1'b0;
          if (bus.dma_mreq)      w_state_nxt = S_IDLE;
          else if (bus.cpu_mreq) w_state_nxt = S_CPU;
          else                   w_state_nxt = S_IDLE;
        end else if (!bus.cpu_mreq) begin
          w_state_nxt = S_IDLE;
        end
      end

      S_DMA: begin
        // Write mask stays forced to zero so the DMA can never write
        w_mem_addr = bus.dma_addr;
        w_mem_mreq = bus.dma_mreq;
        w_dma_mrdy = bus.mem_mrdy;
        if (bus.mem_mrdy) begin
          w_last_nxt = 1'b1;
          w_bcnt_nxt = w_bcnt_inc;
          if (bus.cpu_mreq && w_burst_done) w_state_nxt = S_IDLE;
          else if (bus.dma_mreq)            w_state_nxt = S_DMA;
          else                              w_state_nxt = S_IDLE;
        end else if (!bus.dma_mreq) begin
          w_state_nxt = S_IDLE;
        end
      end

      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign bus.mem_addr  = w_mem_addr;
  assign bus.mem_din   = w_mem_din;
  assign bus.mem_wmask = w_mem_wmask;
  assign bus.mem_mreq  = w_mem_mreq;
  assign bus.cpu_mrdy  = w_cpu_mrdy;
  assign bus.dma_mrdy  = w_dma_mrdy;
  assign bus.cpu_dout  = bus.mem_dout;
  assign bus.dma_dout  = bus.mem_dout;
  assign bus.grant_cpu = (r_state == S_CPU);
  assign bus.grant_dma = (r_state == S_DMA);
endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter: CPU/DMA requesters and a CACHE responder
// driven by $urandom, checked every cycle against an owner-level reference model.
module tb_mem_arbiter;
  localparam int unsigned AW    = 20;
  localparam int unsigned DW    = 32;
  localparam int unsigned BURST = 4;
  localparam int          NCYC  = 4000;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  mem_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  mem_arbiter #(.AW(AW), .DW(DW), .DMA_BURST(BURST)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", tag, cyc, got, exp);
    end
  endtask

  // Requester-side stimulus state held locally by the bench
  logic          cpu_act, dma_act;
  logic [AW-1:0] cpu_a, dma_a;
  logic [DW-1:0] cpu_d, mdout;
  logic [3:0]    cpu_m;
  logic          mrdy;
  logic          cpu_done, dma_done;

  // Reference model: who owns the port, who was served last, DMA completions this grant
  int owner;      // 0 = nobody, 1 = CPU, 2 = DMA
  bit last_dma;
  int run;

  function automatic bit chance(input int pct);
    return ($urandom_range(0, 99) < pct);
  endfunction

  task automatic drive();
    bus.cpu_addr  = cpu_a;
    bus.cpu_din   = cpu_d;
    bus.cpu_wmask = cpu_m;
    bus.cpu_mreq  = cpu_act;
    bus.dma_addr  = dma_a;
    bus.dma_mreq  = dma_act;
    bus.mem_dout  = mdout;
    bus.mem_mrdy  = mrdy;
  endtask

  initial begin
    int cpu_pct, dma_pct;
    logic          e_mreq, e_cmrdy, e_dmrdy;
    logic [AW-1:0] e_addr;
    logic [3:0]    e_wmask;
    int            nxt_owner;

    cpu_act = 1'b0; dma_act = 1'b0;
    cpu_a = '0; dma_a = '0; cpu_d = '0; cpu_m = '0;
    mdout = '0; mrdy = 1'b0;
    cpu_done = 1'b0; dma_done = 1'b0;
    owner = 0; last_dma = 1'b1; run = 0;
    rst = 1'b1;
    drive();
    @(posedge clk); #1;

    for (int i = 0; i < NCYC; i++) begin
      cyc = i;
      // Phases bias the traffic: balanced, DMA streaming with sparse CPU, then heavy both
      if (i < 1000)      begin cpu_pct = 40; dma_pct = 40; end
      else if (i < 2000) begin cpu_pct = 15; dma_pct = 100; end
      else               begin cpu_pct = 80; dma_pct = 80; end

      rst = (i < 2) || ((i > 10) && chance(1));

      if (cpu_act && cpu_done) cpu_act = 1'b0;
      else if (cpu_act && ($urandom_range(0, 39) == 0)) cpu_act = 1'b0;
      else if (!cpu_act && chance(cpu_pct)) begin
        cpu_act = 1'b1;
        cpu_a   = AW'($urandom);
        cpu_d   = DW'($urandom);
        cpu_m   = chance(50) ? 4'h0 : 4'($urandom_range(1, 15));
      end
      if (!cpu_act) cpu_m = 4'($urandom);

      if (dma_act && dma_done) dma_act = 1'b0;
      else if (dma_act && ($urandom_range(0, 39) == 0)) dma_act = 1'b0;
      else if (!dma_act && chance(dma_pct)) begin
        dma_act = 1'b1;
        dma_a   = AW'($urandom);
      end
      if (!cpu_act && chance(50)) cpu_m = 4'hF;

      mrdy  = ($urandom_range(0, 2) == 0);
      mdout = DW'($urandom);
      drive();

      @(negedge clk);
      e_mreq  = (owner == 1) ? cpu_act : (owner == 2) ? dma_act : 1'b0;
      e_addr  = (owner == 2) ? dma_a : cpu_a;
      e_wmask = (owner == 1) ? cpu_m : 4'h0;
      e_cmrdy = (owner == 1) && mrdy;
      e_dmrdy = (owner == 2) && mrdy;

      check("grant_cpu", 64'(bus.grant_cpu), 64'(owner == 1));
      check("grant_dma", 64'(bus.grant_dma), 64'(owner == 2));
      check("mem_mreq",  64'(bus.mem_mreq),  64'(e_mreq));
      check("mem_addr",  64'(bus.mem_addr),  64'(e_addr));
      check("mem_wmask", 64'(bus.mem_wmask), 64'(e_wmask));
      check("mem_din",   64'(bus.mem_din),   64'(cpu_d));
      check("cpu_mrdy",  64'(bus.cpu_mrdy),  64'(e_cmrdy));
      check("dma_mrdy",  64'(bus.dma_mrdy),  64'(e_dmrdy));
      check("cpu_dout",  64'(bus.cpu_dout),  64'(mdout));
      check("dma_dout",  64'(bus.dma_dout),  64'(mdout));

      cpu_done = e_cmrdy;
      dma_done = e_dmrdy;

      // Ownership for the next cycle, decided from this cycle's inputs
      nxt_owner = owner;
      if (rst) begin
        nxt_owner = 0; last_dma = 1'b1; run = 0;
      end else if (owner == 0) begin
        if (cpu_act && dma_act) nxt_owner = last_dma ? 1 : 2;
        else if (cpu_act)       nxt_owner = 1;
        else if (dma_act)       nxt_owner = 2;
        if (nxt_owner == 2) run = 0;
      end else if (owner == 1) begin
        if (mrdy) begin
          last_dma  = 1'b0;
          nxt_owner = (!dma_act && cpu_act) ? 1 : 0;
        end else if (!cpu_act) nxt_owner = 0;
      end else begin
        if (mrdy) begin
          last_dma = 1'b1;
          run = (run < 255) ? run + 1 : 255;
          if (cpu_act && run >= int'(BURST)) nxt_owner = 0;
          else                               nxt_owner = dma_act ? 2 : 0;
        end else if (!dma_act) nxt_owner = 0;
      end

      @(posedge clk); #1;
      owner = nxt_owner;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter that shares the single CPU-side port of the CACHE/SDRAM subsystem between the RISC5 core and a read-only DMA requester, such as a video line fetcher. It sits between the core's memory signals (the `memsel`, `adr`, `wmask`, `inbus0` and `mrdy` path) and the CACHE. Arbitration is round-robin with a bounded DMA burst, and owner changes pass through a one-cycle idle gap.

## Interface

**Parameters**
- AW, default 20: word-address width of the cache port.
- DW, default 32: data width.
- DMA_BURST, default 8: maximum number of consecutive DMA transactions completed while the CPU is waiting. Legal range 1..255.

**Ports**
- clk, in, 1: system clock. The whole block is in this single clock domain.
- rst, in, 1: synchronous, active-high reset.
- cpu_addr, in, AW: CPU address.
- cpu_din, in, DW: CPU write data.
- cpu_wmask, in, 4: CPU byte write mask. All zeros means a read.
- cpu_mreq, in, 1: CPU memory request (level).
- cpu_dout, out, DW: read data to the CPU.
- cpu_mrdy, out, 1: CPU transaction complete.
- dma_addr, in, AW: DMA read address.
- dma_mreq, in, 1: DMA read request (level).
- dma_dout, out, DW: read data to the DMA.
- dma_mrdy, out, 1: DMA transaction complete.
- mem_addr, out, AW: address to the CACHE.
- mem_din, out, DW: write data to the CACHE.
- mem_wmask, out, 4: byte mask to the CACHE.
- mem_mreq, out, 1: request to the CACHE.
- mem_dout, in, DW: read data from the CACHE.
- mem_mrdy, in, 1: CACHE completion.
- grant_cpu, out, 1: current owner is the CPU (registered state decode).
- grant_dma, out, 1: current owner is the DMA (registered state decode).

## Operation

- **Transaction rule:** a requester holds mreq, address, data and mask stable until it samples its mrdy high on a rising edge. That edge completes one transaction.
- **States:** IDLE, CPU, DMA.
  - Registers: `last` (1 bit; 0 = CPU last served, 1 = DMA), reset to 1. `bcnt` (8 bits, saturating), reset to 0.
- **IDLE:**
  - mem_mreq=0, mem_wmask=0, mem_addr=cpu_addr, mem_din=cpu_din.
  - Next state: cpu_mreq & dma_mreq → CPU if last=1, else DMA. Only cpu_mreq → CPU. Only dma_mreq → DMA. Neither → stay IDLE.
  - Entering DMA clears bcnt.
- **CPU:**
  - mem_* = cpu_* combinationally. cpu_mrdy=mem_mrdy. dma_mrdy=0.
  - On mem_mrdy: last←0. Then dma_mreq → IDLE. Else cpu_mreq → stay CPU (back-to-back, no gap). Else → IDLE.
  - cpu_mreq low without mem_mrdy → IDLE (abort).
- **DMA:**
  - mem_addr=dma_addr, mem_wmask=0, mem_din=cpu_din (don't-care), mem_mreq=dma_mreq. dma_mrdy=mem_mrdy. cpu_mrdy=0.
  - On mem_mrdy: last←1, bcnt←bcnt+1 (saturating). Then cpu_mreq & (bcnt+1 ≥ DMA_BURST) → IDLE. Else dma_mreq → stay DMA. Else → IDLE.
  - dma_mreq low without mem_mrdy → IDLE (abort, no count).
- **Read data:** cpu_dout=dma_dout=mem_dout at all times. Only the owner's mrdy qualifies it.
- **Write protection:** the DMA can never write, because mem_wmask is forced to 0 in the DMA state.
- **Simultaneous events:** completion and a new request on the same edge are decided by the rules above. rst wins over everything.

## Timing

- **Reset values:** state=IDLE, last=1, bcnt=0. mem_mreq=0, mem_wmask=0, cpu_mrdy=0, dma_mrdy=0, grant_cpu=0, grant_dma=0.
- **Reset mid-transaction:** the grant drops on the next edge and the CACHE sees mem_mreq fall. The CACHE is responsible for tolerating an abandoned request.
- **Arbitration latency:** a request sampled at edge N in IDLE gives mem_mreq high after edge N+1. CPU worst-case added latency is 1 cycle plus DMA_BURST DMA transactions plus 1 gap cycle.
- **Owner change:** always exactly one IDLE cycle with mem_mreq=0.
- **No combinational path** from mem_mrdy to mem_mreq other than through the registered state. mrdy outputs are combinational from mem_mrdy gated by state.

## Test plan

1. **CPU only.** cpu_mreq held with 3 sequential addresses and the CACHE mrdy 2 cycles after each. Required: grant_cpu from cycle 1, 3 cpu_mrdy pulses, mem_mreq continuous with no gaps, dma_mrdy=0 throughout.
2. **Simultaneous first request after reset.** Both request at edge 0. Required: CPU granted first (last=1). After CPU completion, one IDLE cycle, then DMA granted.
3. **DMA burst limit.** DMA_BURST=4, DMA streaming, cpu_mreq raised mid-burst. Required: exactly 4 dma_mrdy pulses counted from DMA entry, one IDLE cycle, then the CPU transaction. DMA resumes after it with bcnt=0.
4. **DMA write guard.** During DMA ownership, cpu_wmask=4'hF. Required: mem_wmask=0 and mem_addr=dma_addr.
5. **Abort.** dma_mreq drops before mem_mrdy. Required: IDLE next cycle, bcnt unchanged, no dma_mrdy pulse.
6. **Reset mid-CPU-transaction.** rst pulsed for 1 cycle. Required: the next edge has state IDLE, mem_mreq=0, both grants 0, last=1.
